// File: rtl/alu_rs_scheduler.sv
// Reservation station and issue scheduler for a single integer ALU.
// Optional age-ordered select: define ALU_RS_AGE_PRIORITY_EN (default is lowest-index select).
module alu_rs_scheduler #(
  parameter int DEPTH = 8,
  parameter int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            disp_valid,
  output logic            disp_ready,
  input  logic [3:0]      disp_opcode,
  input  logic [15:0]     disp_imm,
  input  logic [15:0]     disp_pc,
  input  logic [15:0]     disp_opr1,
  input  logic [6:0]      disp_opr1_tag,
  input  logic            disp_opr1_rdy,
  input  logic [15:0]     disp_opr2,
  input  logic [6:0]      disp_opr2_tag,
  input  logic            disp_opr2_rdy,
  input  logic [15:0]     disp_prev,
  input  logic [6:0]      disp_prev_tag,
  input  logic            disp_prev_rdy,
  input  logic            disp_c,
  input  logic [7:0]      disp_c_tag,
  input  logic            disp_c_rdy,
  input  logic            disp_z,
  input  logic [7:0]      disp_z_tag,
  input  logic            disp_z_rdy,
  input  logic            disp_neg_opr2,
  input  logic [1:0]      disp_cz_cond,
  input  logic            disp_branch_pred,
  input  logic [6:0]      disp_dest,
  input  logic [2:0]      disp_arch_dest,
  input  logic [7:0]      disp_c_dest,
  input  logic [7:0]      disp_z_dest,
  input  logic [6:0]      disp_rob_idx,
  input  logic            wb_w,
  input  logic [6:0]      wb_rr,
  input  logic [15:0]     wb_d,
  input  logic            wb_c_w,
  input  logic [7:0]      wb_c_rr,
  input  logic            wb_c,
  input  logic            wb_z_w,
  input  logic [7:0]      wb_z_rr,
  input  logic            wb_z,
  input  logic            flush,
  input  logic [6:0]      rob_head,
  output logic            iss_valid,
  output logic [3:0]      iss_opcode,
  output logic [15:0]     iss_imm,
  output logic [15:0]     iss_pc,
  output logic [15:0]     iss_opr1,
  output logic [15:0]     iss_opr2,
  output logic [15:0]     iss_prev,
  output logic            iss_c,
  output logic            iss_z,
  output logic            iss_neg_opr2,
  output logic [1:0]      iss_cz_cond,
  output logic            iss_branch_pred,
  output logic [6:0]      iss_dest,
  output logic [2:0]      iss_arch_dest,
  output logic [7:0]      iss_c_dest,
  output logic [7:0]      iss_z_dest,
  output logic [6:0]      iss_rob_idx,
  output logic [CNTW-1:0] rs_count
);
  localparam int IDXW = $clog2(DEPTH);

  typedef struct packed {
    logic [3:0]  opcode;
    logic [15:0] imm;
    logic [15:0] pc;
    logic [15:0] opr1;
    logic [6:0]  opr1_tag;
    logic        opr1_rdy;
    logic [15:0] opr2;
    logic [6:0]  opr2_tag;
    logic        opr2_rdy;
    logic [15:0] prev;
    logic [6:0]  prev_tag;
    logic        prev_rdy;
    logic        c;
    logic [7:0]  c_tag;
    logic        c_rdy;
    logic        z;
    logic [7:0]  z_tag;
    logic        z_rdy;
    logic        neg_opr2;
    logic [1:0]  cz_cond;
    logic        branch_pred;
    logic [6:0]  dest;
    logic [2:0]  arch_dest;
    logic [7:0]  c_dest;
    logic [7:0]  z_dest;
    logic [6:0]  rob_idx;
  } entry_t;

  entry_t [DEPTH-1:0] ent_q, ent_d;
  logic   [DEPTH-1:0] valid_q, valid_d;
  entry_t             iss_q, iss_d;
  logic               iss_valid_q, iss_valid_d;
  entry_t             disp_ent;
  logic   [DEPTH-1:0] elig;
  logic               sel_found, free_found;
  logic   [IDXW-1:0]  sel_idx, free_idx;
  logic   [CNTW-1:0]  cnt;

  // Capture any matching broadcast into a not-yet-ready source.
  function automatic entry_t wake(input entry_t e,
                                  input logic ww, input logic [6:0] wrr, input logic [15:0] wd,
                                  input logic cw, input logic [7:0] crr, input logic cv,
                                  input logic zw, input logic [7:0] zrr, input logic zv);
    entry_t r;
    r = e;
    if (!e.opr1_rdy && ww && e.opr1_tag == wrr) begin r.opr1 = wd; r.opr1_rdy = 1'b1; end
    if (!e.opr2_rdy && ww && e.opr2_tag == wrr) begin r.opr2 = wd; r.opr2_rdy = 1'b1; end
    if (!e.prev_rdy && ww && e.prev_tag == wrr) begin r.prev = wd; r.prev_rdy = 1'b1; end
    if (!e.c_rdy && cw && e.c_tag == crr) begin r.c = cv; r.c_rdy = 1'b1; end
    if (!e.z_rdy && zw && e.z_tag == zrr) begin r.z = zv; r.z_rdy = 1'b1; end
    return r;
  endfunction

  always_comb begin
    disp_ent = '{opcode: disp_opcode, imm: disp_imm, pc: disp_pc,
                 opr1: disp_opr1, opr1_tag: disp_opr1_tag, opr1_rdy: disp_opr1_rdy,
                 opr2: disp_opr2, opr2_tag: disp_opr2_tag, opr2_rdy: disp_opr2_rdy,
                 prev: disp_prev, prev_tag: disp_prev_tag, prev_rdy: disp_prev_rdy,
                 c: disp_c, c_tag: disp_c_tag, c_rdy: disp_c_rdy,
                 z: disp_z, z_tag: disp_z_tag, z_rdy: disp_z_rdy,
                 neg_opr2: disp_neg_opr2, cz_cond: disp_cz_cond,
                 branch_pred: disp_branch_pred, dest: disp_dest,
                 arch_dest: disp_arch_dest, c_dest: disp_c_dest,
                 z_dest: disp_z_dest, rob_idx: disp_rob_idx};
    cnt = '0;
    free_found = 1'b0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = valid_q[i] && ent_q[i].opr1_rdy && ent_q[i].opr2_rdy &&
                ent_q[i].prev_rdy && ent_q[i].c_rdy && ent_q[i].z_rdy;
      cnt = cnt + CNTW'(valid_q[i]);
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx = IDXW'(i);
      end
    end
  end

`ifdef ALU_RS_AGE_PRIORITY_EN
  logic [6:0] dist, best_dist;
  // Oldest by ROB distance from head wins; strict compare keeps ties on the lower index.
  always_comb begin
    sel_found = 1'b0;
    sel_idx = '0;
    dist = '0;
    best_dist = '0;
    for (int i = 0; i < DEPTH; i++) begin
      dist = ent_q[i].rob_idx - rob_head;
      if (elig[i] && (!sel_found || dist < best_dist)) begin
        sel_found = 1'b1;
        sel_idx = IDXW'(i);
        best_dist = dist;
      end
    end
  end
`else
  logic unused_rob_head;
  assign unused_rob_head = ^rob_head;
  always_comb begin
    sel_found = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (elig[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx = IDXW'(i);
      end
    end
  end
`endif

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++)
      ent_d[i] = wake(ent_q[i], wb_w, wb_rr, wb_d, wb_c_w, wb_c_rr, wb_c, wb_z_w, wb_z_rr, wb_z);
    if (sel_found) valid_d[sel_idx] = 1'b0;
    if (disp_valid && free_found) begin
      valid_d[free_idx] = 1'b1;
      ent_d[free_idx] = wake(disp_ent, wb_w, wb_rr, wb_d, wb_c_w, wb_c_rr, wb_c,
                             wb_z_w, wb_z_rr, wb_z);
    end
    iss_valid_d = sel_found && !flush;
    iss_d = '0;
    if (iss_valid_d) iss_d = ent_q[sel_idx];
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q       <= '0;
      valid_q     <= '0;
      iss_q       <= '0;
      iss_valid_q <= 1'b0;
    end else begin
      ent_q       <= ent_d;
      valid_q     <= valid_d;
      iss_q       <= iss_d;
      iss_valid_q <= iss_valid_d;
    end
  end

  assign disp_ready      = free_found;
  assign rs_count        = cnt;
  assign iss_valid       = iss_valid_q;
  assign iss_opcode      = iss_q.opcode;
  assign iss_imm         = iss_q.imm;
  assign iss_pc          = iss_q.pc;
  assign iss_opr1        = iss_q.opr1;
  assign iss_opr2        = iss_q.opr2;
  assign iss_prev        = iss_q.prev;
  assign iss_c           = iss_q.c;
  assign iss_z           = iss_q.z;
  assign iss_neg_opr2    = iss_q.neg_opr2;
  assign iss_cz_cond     = iss_q.cz_cond;
  assign iss_branch_pred = iss_q.branch_pred;
  assign iss_dest        = iss_q.dest;
  assign iss_arch_dest   = iss_q.arch_dest;
  assign iss_c_dest      = iss_q.c_dest;
  assign iss_z_dest      = iss_q.z_dest;
  assign iss_rob_idx     = iss_q.rob_idx;
endmodule

// File: doc/alu_rs_scheduler.md
# alu_rs_scheduler

Reservation station and issue scheduler for one integer ALU. Sits between rename/dispatch and the combinational ALU. Buffers up to DEPTH dispatched instructions and captures operand, carry and zero values from writeback tag broadcasts. Issues one ready instruction per cycle through a registered ALU input bundle and drops all contents on a pipeline flush.

## Interface
- DEPTH, 8, number of RS entries (power of two, 2..16)
- CNTW, $clog2(DEPTH)+1, width of occupancy count
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- disp_valid  in  1  dispatch request
- disp_ready  out  1  a free entry exists (combinational from current valid bits)
- disp_opcode / disp_imm / disp_pc  in  4/16/16  instruction fields
- disp_opr1, disp_opr1_tag, disp_opr1_rdy  in  16/7/1  operand 1 value, producer RR tag, value-valid
- disp_opr2, disp_opr2_tag, disp_opr2_rdy  in  16/7/1  operand 2, same meaning
- disp_prev, disp_prev_tag, disp_prev_rdy  in  16/7/1  previous destination value (conditional ops)
- disp_c, disp_c_tag, disp_c_rdy  in  1/8/1  carry source
- disp_z, disp_z_tag, disp_z_rdy  in  1/8/1  zero source
- disp_neg_opr2 / disp_cz_cond / disp_branch_pred  in  1/2/1  control bits
- disp_dest / disp_arch_dest / disp_c_dest / disp_z_dest / disp_rob_idx  in  7/3/8/8/7  destination tags
- wb_w, wb_rr, wb_d  in  1/7/16  register writeback broadcast
- wb_c_w, wb_c_rr, wb_c  in  1/8/1  carry writeback broadcast
- wb_z_w, wb_z_rr, wb_z  in  1/8/1  zero writeback broadcast
- flush  in  1  synchronous kill of all entries (mispredict recovery)
- rob_head  in  7  oldest ROB index, used only with age priority
- iss_valid  out  1  registered issue strobe, drives ALU valid
- iss_*  out  —  registered copies of every stored field, value fields already resolved
- rs_count  out  CNTW  number of valid entries

## Operation
- Per entry: valid bit, all disp_* fields, and a ready bit per source (opr1, opr2, prev, c, z).
- Dispatch: when disp_valid & disp_ready, the lowest-index free entry is written.
- Wakeup applies to each valid entry source with rdy=0. A 7-bit tag match with wb_rr while wb_w=1 captures wb_d and sets rdy. Carry and zero match 8-bit tags against wb_c_rr/wb_z_rr under wb_c_w/wb_z_w.
- Dispatch bypass: an incoming not-ready source that matches a broadcast in the same cycle is written as ready with the broadcast value.
- Entry is eligible when valid and all five ready bits are set.
- Select: one eligible entry per cycle, lowest index. It is copied into the iss_* registers and its valid bit is cleared on the same edge.
- No eligible entry: iss_valid=0 and all iss_* registers are 0.
- ALU accepts every cycle; there is no backpressure.
- Full (DEPTH valid): disp_ready=0. An entry freed by issue becomes usable on the following cycle.
- flush: on that edge all valid bits and iss_valid clear, and any dispatch in that cycle is dropped. Wakeups in the flush cycle are discarded.

## Timing
- Reset (async, rst_n=0): all valid=0, iss_valid=0, all iss_*=0, rs_count=0, disp_ready=1.
- Fully ready dispatch at edge N: eligible in cycle N+1, iss_valid high after edge N+1.
- Wakeup at edge N: eligible in cycle N+1. There is no same-cycle wakeup-to-select.
- Issue throughput is 1 per cycle. Dispatch throughput is 1 per cycle while not full.
- rs_count updates on the same edge as dispatch, issue or flush. Simultaneous dispatch and issue leaves the count unchanged.
- rst_n asserted mid-operation clears everything immediately. The first dispatch is accepted on the first edge after release.

## Configuration
- ALU_RS_AGE_PRIORITY_EN defined: select picks the eligible entry whose rob_idx has the smallest (rob_idx - rob_head) mod 128 distance; ties go to lowest index.
- ALU_RS_AGE_PRIORITY_EN undefined: lowest-index priority, and rob_head is ignored.

## Test plan
- Reset, then dispatch ADD (opcode 0001) with opr1=5, opr2=7, all sources ready -> iss_valid pulses 1 cycle after dispatch edge; iss_opr1=5, iss_opr2=7; rs_count 1->0.
- Dispatch with opr2 tag 0x12 not ready, then wb_w=1, wb_rr=0x12, wb_d=0x00FF two cycles later -> issue one cycle after the broadcast with iss_opr2=0x00FF.
- Dispatch in the same cycle as a matching broadcast (wb_rr equals disp_opr1_tag, wb_d=0xBEEF) -> entry issues the next cycle with iss_opr1=0xBEEF.
- Fill 8 entries, all blocked on carry tag 0x40 -> disp_ready=0 and rs_count=8. Broadcast wb_c_rr=0x40 -> 8 consecutive issues in index order.
- Hold 5 entries, assert flush while a dispatch arrives -> next cycle rs_count=0, iss_valid=0, dispatched entry never issues.
- With ALU_RS_AGE_PRIORITY_EN, rob_head=0x7E, ready entries at index0 (rob 0x02) and index1 (rob 0x7F) -> rob 0x7F issues first.
